// File: rtl/switch_port_out_buffer.sv
// ---------------------------------------------------------------------------
// switch_port_out_buffer
//
// Output stage of the switch. There is one FIFO per output port. A shared
// write bus from the switch core feeds the FIFOs, and a port mask selects the
// targets, so one word can be multicast to several ports in a single cycle.
// Each port drains independently through its port/read/ready handshake.
//
// Ports:
//   clock      in   single clock; all logic on posedge
//   reset      in   synchronous, active-high
//   wr_data    in   DATA_W        word from switch core
//   wr_valid   in   1             write request
//   wr_mask    in   NUM_PORTS     target ports (bit i = port i)
//   wr_ready   out  1             write accepted this cycle when wr_valid=1
//   port       out  NUM_PORTS*DATA_W  registered FWFT head word per port
//   read       in   NUM_PORTS     per-port pop request
//   ready      out  NUM_PORTS     FIFO i non-empty
//   level      out  NUM_PORTS*LVL_W   per-port occupancy 0..DEPTH
//   underflow  out  NUM_PORTS     one-cycle pulse after read[i] while !ready[i]
//   drop_cnt   out  NUM_PORTS*16  (PORT_BUF_DROP_EN only) saturating drop count
//
// Optional build macro PORT_BUF_DROP_EN:
//   When it is defined, wr_ready is tied high. A full target port drops the
//   word and counts the drop, while the other masked ports still take it.
//   When it is undefined, a single full target port back-pressures the whole
//   write, which keeps multicast atomic.
//
// DEPTH must be a power of two and at least 2, because the pointers wrap
// naturally.
// ---------------------------------------------------------------------------
module switch_port_out_buffer #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_PORTS = 4,
  parameter  int DEPTH     = 8,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_valid,
  input  logic [NUM_PORTS-1:0]        wr_mask,
  output logic                        wr_ready,
  output logic [NUM_PORTS*DATA_W-1:0] port,
  input  logic [NUM_PORTS-1:0]        read,
  output logic [NUM_PORTS-1:0]        ready,
  output logic [NUM_PORTS*LVL_W-1:0]  level,
  output logic [NUM_PORTS-1:0]        underflow
`ifdef PORT_BUF_DROP_EN
  ,
  output logic [NUM_PORTS*16-1:0]     drop_cnt
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

`ifdef PORT_BUF_DROP_EN
  logic [NUM_PORTS-1:0] drop;

  // Never back-pressure. Full targets lose the word; the rest still push.
  assign wr_ready = 1'b1;
  assign push     = {NUM_PORTS{wr_valid}} & wr_mask & ~full;
  assign drop     = {NUM_PORTS{wr_valid}} & wr_mask & full;
`else
  // A write is all-or-nothing. Fullness is the pre-pop level, so a full
  // port blocks the write even while it is being read.
  assign wr_ready = ~|(wr_mask & full);
  assign push     = {NUM_PORTS{wr_valid & wr_ready}} & wr_mask;
`endif

  // A read on an empty FIFO is ignored and shows up as an underflow pulse.
  assign pop = read & ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  rptr_nxt;
    logic [LVL_W-1:0]  cnt;
    logic [LVL_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_nxt;
    logic              uf;

    assign full[i]  = (cnt == FULL_LVL);
    assign ready[i] = (cnt != '0);
    assign rptr_nxt = rptr + PTR_W'(pop[i]);

    always_comb begin
      cnt_nxt = cnt;
      if (push[i] && !pop[i]) begin
        cnt_nxt = cnt + LVL_W'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_nxt = cnt - LVL_W'(1);
      end
    end

    // Head register for first-word fall-through. If the FIFO will hold only
    // the incoming word after this edge, wr_data bypasses the memory.
    // Otherwise the word at the post-pop read pointer is loaded. When the
    // FIFO goes empty, the head keeps its last value.
    always_comb begin
      head_nxt = head;
      if (push[i] && (cnt == LVL_W'(pop[i]))) begin
        head_nxt = wr_data;
      end else if (cnt > LVL_W'(pop[i])) begin
        head_nxt = mem[rptr_nxt];
      end
    end

    // ---- registered state: pointers, level, head, underflow pulse ----
    always_ff @(posedge clock) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
        head <= '0;
        uf   <= 1'b0;
      end else begin
        if (push[i]) begin
          wptr <= wptr + PTR_W'(1);
        end
        rptr <= rptr_nxt;
        cnt  <= cnt_nxt;
        head <= head_nxt;
        uf   <= read[i] & ~ready[i];
      end
    end

    // Storage needs no reset. Reset empties the FIFO through the pointers.
    always_ff @(posedge clock) begin
      if (push[i]) begin
        mem[wptr] <= wr_data;
      end
    end

    assign port[i*DATA_W +: DATA_W] = head;
    assign level[i*LVL_W +: LVL_W]  = cnt;
    assign underflow[i]             = uf;

`ifdef PORT_BUF_DROP_EN
    logic [15:0] dcnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        dcnt <= '0;
      end else if (drop[i] && (dcnt != 16'hFFFF)) begin
        dcnt <= dcnt + 16'd1;
      end
    end

    assign drop_cnt[i*16 +: 16] = dcnt;
`endif
  end : g_port

endmodule

// File: tb/tb_switch_port_out_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for switch_port_out_buffer (default parameters).
// The reference model keeps one queue per port and applies the buffer rules
// at each clock edge. Directed scenarios run first, followed by randomized
// traffic with a reset in the middle.
// ---------------------------------------------------------------------------
module tb_switch_port_out_buffer;
  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 4;
  localparam int DEPTH     = 8;
  localparam int LVL_W     = 4;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [DATA_W-1:0]           wr_data;
  logic                        wr_valid;
  logic [NUM_PORTS-1:0]        wr_mask;
  logic                        wr_ready;
  logic [NUM_PORTS*DATA_W-1:0] port;
  logic [NUM_PORTS-1:0]        read;
  logic [NUM_PORTS-1:0]        ready;
  logic [NUM_PORTS*LVL_W-1:0]  level;
  logic [NUM_PORTS-1:0]        underflow;
`ifdef PORT_BUF_DROP_EN
  logic [NUM_PORTS*16-1:0]     drop_cnt;
`endif

  switch_port_out_buffer #(
    .DATA_W   (DATA_W),
    .NUM_PORTS(NUM_PORTS),
    .DEPTH    (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_mask  (wr_mask),
    .wr_ready (wr_ready),
    .port     (port),
    .read     (read),
    .ready    (ready),
    .level    (level),
    .underflow(underflow)
`ifdef PORT_BUF_DROP_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DATA_W-1:0] mq    [NUM_PORTS][$];
  logic [DATA_W-1:0] mhead [NUM_PORTS];
  logic [NUM_PORTS-1:0] muf;
  int                mdrop [NUM_PORTS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_PORTS; i++) begin
      mq[i].delete();
      mhead[i] = '0;
      mdrop[i] = 0;
    end
    muf = '0;
  endtask

  function automatic logic model_wr_ready(input logic [NUM_PORTS-1:0] m);
    logic blk;
    blk = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (m[i] && mq[i].size() == DEPTH) blk = 1'b1;
`ifdef PORT_BUF_DROP_EN
    blk = 1'b0;
`endif
    return !blk;
  endfunction

  // One clock edge of the model. All decisions use the pre-edge occupancy.
  task automatic model_edge(input logic [DATA_W-1:0] d, input logic v,
                            input logic [NUM_PORTS-1:0] m, input logic [NUM_PORTS-1:0] r);
    logic acc;
    int   sz;
    acc = v && model_wr_ready(m);
    for (int i = 0; i < NUM_PORTS; i++) begin
      sz = mq[i].size();
      muf[i] = r[i] && (sz == 0);
      if (r[i] && sz > 0) void'(mq[i].pop_front());
      if (acc && m[i]) begin
        if (sz == DEPTH) begin
          if (mdrop[i] < 65535) mdrop[i]++;
        end else begin
          mq[i].push_back(d);
        end
      end
      if (mq[i].size() > 0) mhead[i] = mq[i][0];
    end
  endtask

  task automatic check_outs();
    logic [NUM_PORTS-1:0]        er;
    logic [NUM_PORTS*LVL_W-1:0]  el;
    logic [NUM_PORTS*DATA_W-1:0] ep;
`ifdef PORT_BUF_DROP_EN
    logic [NUM_PORTS*16-1:0]     ed;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      er[i]                 = (mq[i].size() != 0);
      el[i*LVL_W +: LVL_W]  = LVL_W'(mq[i].size());
      ep[i*DATA_W +: DATA_W] = mhead[i];
`ifdef PORT_BUF_DROP_EN
      ed[i*16 +: 16]        = 16'(mdrop[i]);
`endif
    end
    chk("ready", ready, er);
    chk("level", level, el);
    chk("port", port, ep);
    chk("underflow", underflow, muf);
`ifdef PORT_BUF_DROP_EN
    chk("drop_cnt", drop_cnt, ed);
`endif
  endtask

  // Drive one cycle from a negedge and check wr_ready combinationally. Then
  // step the model on the posedge and check all outputs at the next negedge.
  task automatic cyc(input logic [DATA_W-1:0] d, input logic v,
                     input logic [NUM_PORTS-1:0] m, input logic [NUM_PORTS-1:0] r);
    wr_data  = d;
    wr_valid = v;
    wr_mask  = m;
    read     = r;
    #1;
    chk("wr_ready", wr_ready, model_wr_ready(m));
    @(posedge clock);
    model_edge(d, v, m, r);
    @(negedge clock);
    check_outs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_data  = '0;
    wr_valid = 1'b0;
    wr_mask  = '0;
    read     = '0;
    @(posedge clock);
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    check_outs();
  endtask

  initial begin
    logic [NUM_PORTS-1:0] r;
    int rp;

    reset = 1'b1; wr_data = '0; wr_valid = 1'b0; wr_mask = '0; read = '0;
    do_reset();

    // Idle after reset
    repeat (5) cyc(8'h00, 1'b0, 4'b0000, 4'b0000);
    chk("idle_ready", ready, 4'b0000);
    chk("idle_level", level, 16'h0000);

    // Multicast, then pop port 0
    cyc(8'hA5, 1'b1, 4'b0101, 4'b0000);
    chk("mc_port0", port[7:0], 8'hA5);
    chk("mc_port2", port[23:16], 8'hA5);
    chk("mc_ready", ready, 4'b0101);
    cyc(8'h00, 1'b0, 4'b0000, 4'b0001);
    chk("mc_ready_after", ready, 4'b0100);
    chk("mc_level0", level[3:0], 4'd0);
    chk("mc_level2", level[11:8], 4'd1);

    // Fill port 1, then a multicast to a full port
    for (int k = 0; k < 8; k++) cyc(8'(16 + k), 1'b1, 4'b0010, 4'b0000);
    chk("p1_full_level", level[7:4], 4'd8);
    cyc(8'h55, 1'b1, 4'b0011, 4'b0000);
`ifndef PORT_BUF_DROP_EN
    chk("blocked_p0_empty", ready[0], 1'b0);
`endif
    for (int k = 0; k < 8; k++) begin
      chk("p1_order", port[15:8], 8'(16 + k));
      cyc(8'h00, 1'b0, 4'b0000, 4'b0010);
    end
    chk("p1_drained", ready[1], 1'b0);

    // Port 3 holding 3 words, then push and pop together
    for (int k = 0; k < 3; k++) cyc(8'(48 + k), 1'b1, 4'b1000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      chk("p3_stream_head", port[31:24], (k < 3) ? 8'(48 + k) : 8'(64 + k - 3));
      cyc(8'(64 + k), 1'b1, 4'b1000, 4'b1000);
      chk("p3_stream_level", level[15:12], 4'd3);
    end
    repeat (3) cyc(8'h00, 1'b0, 4'b0000, 4'b1000);

    // Underflow on an empty port
    cyc(8'h00, 1'b0, 4'b0000, 4'b1000);
    chk("uf_pulse", underflow, 4'b1000);
    chk("uf_level3", level[15:12], 4'd0);
    cyc(8'h00, 1'b0, 4'b0000, 4'b0000);
    chk("uf_cleared", underflow, 4'b0000);

`ifdef PORT_BUF_DROP_EN
    // Port 2 already holds A5; top it up to full, then write to ports 1 and 2
    for (int k = 0; k < 7; k++) cyc(8'(k), 1'b1, 4'b0100, 4'b0000);
    cyc(8'h77, 1'b1, 4'b0110, 4'b0000);
    chk("drop_cnt2", drop_cnt[47:32], 16'd1);
    chk("drop_p1_pushed", port[15:8], 8'h77);
`endif

    // Randomized traffic. Light-read phases fill the FIFOs, heavy-read phases
    // drain them, and a reset comes midway with data buffered.
    for (int ph = 0; ph < 4; ph++) begin
      rp = (ph % 2 == 0) ? 20 : 70;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < NUM_PORTS; i++) r[i] = ($urandom_range(0, 99) < rp);
        cyc(8'($urandom), ($urandom_range(0, 99) < 70), 4'($urandom), r);
      end
      if (ph == 1) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
